// File: rtl/cpu_param.sv
// Parametrised teaching CPU: 8-entry register file (r5 = buttons, r6 = LEDs, r7 = pc),
// flags C/Z, hardware return stack, halt and run/single-step control, plus LED-matrix scan.
module cpu_param #(
    parameter int unsigned DATA_W      = 4,
    parameter int unsigned PC_W        = 4,
    parameter int unsigned IMM_W       = 4,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned INSTR_W     = 5 + IMM_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               step,
    input  logic [DATA_W-1:0]  btn,
    input  logic [2:0]         scan_sel,
    input  logic [INSTR_W-1:0] dout,
    output logic [DATA_W-1:0]  led,
    output logic [PC_W-1:0]    adr,
    output logic [7:0]         col,
    output logic [7:0]         row,
    output logic               halted,
    output logic               stack_err
);

    localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [DATA_W-1:0] r_q [7];
    logic [DATA_W-1:0] r_d [7];
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              c_q, c_d, z_q, z_d;
    logic              halt_q, halt_d, err_q, err_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [PC_W-1:0]   stk_q [STACK_DEPTH];

    logic [DATA_W-1:0] rv [8];
    logic [4:0]        op;
    logic [IMM_W-1:0]  opd;
    logic [DATA_W-1:0] rs, res;
    logic [DATA_W:0]   sum;
    logic [PC_W-1:0]   pc_inc;
    logic              exec, wr_en, set_z, push;
    logic [2:0]        wr_idx;
    logic [IDX_W-1:0]  push_idx, pop_idx;

    // Read view of the register file; r7 aliases the program counter.
    always_comb begin
        for (int unsigned i = 0; i < 7; i++) rv[i] = r_q[i];
        rv[7] = DATA_W'(pc_q);
    end

    always_comb begin
        op       = dout[INSTR_W-1 -: 5];
        opd      = dout[IMM_W-1:0];
        rs       = rv[opd[2:0]];
        pc_inc   = pc_q + PC_W'(1);
        exec     = !halt_q && (run || step);
        push_idx = sp_q[IDX_W-1:0];
        pop_idx  = IDX_W'(sp_q - SP_W'(1));
        r_d      = r_q;
        pc_d     = pc_q;
        c_d      = c_q;
        z_d      = z_q;
        halt_d   = halt_q;
        err_d    = err_q;
        sp_d     = sp_q;
        push     = 1'b0;
        res      = '0;
        sum      = '0;
        wr_en    = 1'b0;
        wr_idx   = 3'd0;
        set_z    = 1'b0;
        if (exec) begin
            pc_d = pc_inc;
            casez (op)
                5'b00???: begin wr_en = 1'b1; wr_idx = op[2:0]; res = rs; end
                5'b01000: begin
                    sum   = {1'b0, rv[0]} + {1'b0, rs};
                    res   = sum[DATA_W-1:0];
                    c_d   = sum[DATA_W];
                    wr_en = 1'b1; set_z = 1'b1;
                end
                5'b10100: begin
                    res   = rv[0] - rs;
                    c_d   = (rv[0] < rs);
                    wr_en = 1'b1; set_z = 1'b1;
                end
                5'b01001: begin res = rv[0] | rs; wr_en = 1'b1; set_z = 1'b1; end
                5'b01010: begin res = rv[0] & rs; wr_en = 1'b1; set_z = 1'b1; end
                5'b01011: begin res = rv[0] ^ rs; wr_en = 1'b1; set_z = 1'b1; end
                5'b01100: begin
                    res   = rs + DATA_W'(1);
                    c_d   = &rs;
                    wr_en = 1'b1; wr_idx = opd[2:0]; set_z = 1'b1;
                end
                5'b01101: begin res = ~rs; wr_en = 1'b1; wr_idx = opd[2:0]; set_z = 1'b1; end
                5'b01110: begin res = {rs[0], rs[DATA_W-1:1]}; wr_en = 1'b1; wr_idx = opd[2:0]; end
                5'b01111: begin res = {rs[DATA_W-2:0], rs[DATA_W-1]}; wr_en = 1'b1; wr_idx = opd[2:0]; end
                5'b10000: begin
                    if (!c_q) pc_d = opd[PC_W-1:0];
                    c_d = 1'b0;
                end
                5'b10001: pc_d = opd[PC_W-1:0];
                5'b10010: begin res = opd[DATA_W-1:0]; wr_en = 1'b1; end
                5'b10011: if (z_q) pc_d = opd[PC_W-1:0];
                5'b10101: begin
                    if (sp_q < SP_W'(STACK_DEPTH)) begin
                        push = 1'b1;
                        sp_d = sp_q + SP_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                    pc_d = opd[PC_W-1:0];
                end
                5'b10110: begin
                    if (sp_q != '0) begin
                        sp_d = sp_q - SP_W'(1);
                        pc_d = stk_q[pop_idx];
                    end else begin
                        err_d = 1'b1;
                    end
                end
                5'b10111: begin halt_d = 1'b1; pc_d = pc_q; end
                default: ;
            endcase
            if (set_z) z_d = (res == '0);
            // A write aimed at r7 becomes a jump; writes aimed at r5 are dropped.
            if (wr_en) begin
                if (wr_idx == 3'd7) pc_d = PC_W'(res);
                for (int unsigned i = 0; i < 7; i++) begin
                    if (wr_idx == 3'(i) && i != 5) r_d[i] = res;
                end
            end
        end
        r_d[5] = btn;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 7; i++) r_q[i] <= '0;
            pc_q   <= '0;
            c_q    <= 1'b0;
            z_q    <= 1'b0;
            halt_q <= 1'b0;
            err_q  <= 1'b0;
            sp_q   <= '0;
        end else begin
            r_q    <= r_d;
            pc_q   <= pc_d;
            c_q    <= c_d;
            z_q    <= z_d;
            halt_q <= halt_d;
            err_q  <= err_d;
            sp_q   <= sp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) stk_q[push_idx] <= pc_inc;
    end

    always_comb begin
        col = ~(8'h80 >> scan_sel);
        row = '0;
        for (int unsigned k = 0; k < DATA_W; k++) row[7-k] = rv[scan_sel][k];
    end

    assign led       = r_q[6];
    assign adr       = pc_q;
    assign halted    = halt_q;
    assign stack_err = err_q;

endmodule

// File: tb/tb_cpu_param.sv
// Directed bench for cpu_param: ROM programs per scenario, expectations queued in a
// scoreboard and popped when the corresponding DUT output is sampled.
module tb_cpu_param;

    logic       clk = 1'b0;
    logic       reset, run, step;
    logic [3:0] btn;
    logic [2:0] scan_sel;
    logic [8:0] dout;
    logic [3:0] led;
    logic [3:0] adr;
    logic [7:0] col, row;
    logic       halted, stack_err;

    logic [8:0] rom [16];
    assign dout = rom[adr];

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sbq[$];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cpu_param #(.DATA_W(4), .PC_W(4), .IMM_W(4), .STACK_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .run(run), .step(step), .btn(btn),
        .scan_sel(scan_sel), .dout(dout), .led(led), .adr(adr),
        .col(col), .row(row), .halted(halted), .stack_err(stack_err)
    );

    function automatic logic [8:0] ins(input logic [4:0] op, input logic [3:0] o);
        return {op, o};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 9'b11000_0000;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic start(input logic r);
        @(negedge clk);
        reset = 1'b0;
        run   = r;
        step  = 1'b0;
        #1 reset = 1'b1;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        sbq.push_back('{tag, v});
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        tests++;
        if (sbq.size() == 0) begin
            fails++;
            $error("FAIL scoreboard_empty: observed %0h, required a queued entry", obs);
            return;
        end
        e = sbq.pop_front();
        assert (obs === e.val) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
        end
    endtask

    task automatic read_reg(input logic [2:0] k, output logic [3:0] v);
        scan_sel = k;
        #1 v = {row[4], row[5], row[6], row[7]};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] v;
        int seq1 [5] = '{1, 2, 1, 2, 1};
        int seq4 [7] = '{4, 8, 12, 5, 1, 2, 2};
        int err4 [7] = '{0, 0, 1, 1, 1, 1, 1};

        reset = 1'b1; run = 1'b0; step = 1'b0; btn = 4'd0; scan_sel = 3'd0;
        clear_rom();
        rom[0] = ins(5'b10010, 4'd3);
        rom[1] = ins(5'b00110, 4'd0);
        rom[2] = ins(5'b10001, 4'd1);
        #2 reset = 1'b0;
        #1;
        expect_val("rst_led", 0);       check(led);
        expect_val("rst_adr", 0);       check(adr);
        expect_val("rst_halted", 0);    check(halted);
        expect_val("rst_stack_err", 0); check(stack_err);

        // Loop program: MVI 3; MOV r6,r0; JMP 1
        @(negedge clk);
        reset = 1'b1; run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            expect_val($sformatf("loop_adr%0d", i), seq1[i]); check(adr);
            if (i == 0) begin expect_val("led_cycle1", 0); check(led); end
            if (i == 1) begin expect_val("led_cycle2", 3); check(led); end
        end
        #1 reset = 1'b0;
        #1;
        expect_val("async_rst_adr", 0); check(adr);
        expect_val("async_rst_led", 0); check(led);

        // ADD with carry, JNC fall-through, JZ taken, C cleared by JNC
        clear_rom();
        rom[0] = ins(5'b10010, 4'd15);
        rom[1] = ins(5'b00001, 4'd0);
        rom[2] = ins(5'b10010, 4'd1);
        rom[3] = ins(5'b01000, 4'd1);
        rom[4] = ins(5'b10000, 4'd0);
        rom[5] = ins(5'b10011, 4'd7);
        rom[7] = ins(5'b10000, 4'd9);
        rom[9] = ins(5'b10111, 4'd0);
        start(1'b1);
        tick(4);
        read_reg(3'd0, v); expect_val("add_r0", 0);  check(v);
        read_reg(3'd1, v); expect_val("add_r1", 15); check(v);
        tick(1); expect_val("jnc_carry_fallthru", 5); check(adr);
        tick(1); expect_val("jz_taken_z1", 7);        check(adr);
        tick(1); expect_val("jnc_after_clear", 9);    check(adr);
        tick(1); expect_val("hlt_halted", 1);         check(halted);
        tick(3); expect_val("hlt_adr_hold", 9);       check(adr);

        // SUB with borrow, flag-driven branches
        clear_rom();
        rom[0]  = ins(5'b10010, 4'd3);
        rom[1]  = ins(5'b00001, 4'd0);
        rom[2]  = ins(5'b10010, 4'd2);
        rom[3]  = ins(5'b10100, 4'd1);
        rom[4]  = ins(5'b10011, 4'd15);
        rom[5]  = ins(5'b10000, 4'd15);
        rom[6]  = ins(5'b10010, 4'd0);
        rom[7]  = ins(5'b01001, 4'd0);
        rom[8]  = ins(5'b10011, 4'd11);
        rom[11] = ins(5'b10111, 4'd0);
        start(1'b1);
        tick(4);
        read_reg(3'd0, v); expect_val("sub_r0", 15); check(v);
        expect_val("sub_adr", 4); check(adr);
        tick(1); expect_val("jz_not_taken_z0", 5);  check(adr);
        tick(1); expect_val("jnc_borrow_fallthru", 6); check(adr);
        tick(2); read_reg(3'd0, v); expect_val("or_r0_zero", 0); check(v);
        tick(1); expect_val("jz_taken_after_or", 11); check(adr);

        // Return stack of depth 2: overflow, LIFO returns, underflow
        clear_rom();
        rom[0]  = ins(5'b10101, 4'd4);
        rom[1]  = ins(5'b10110, 4'd0);
        rom[2]  = ins(5'b10111, 4'd0);
        rom[4]  = ins(5'b10101, 4'd8);
        rom[5]  = ins(5'b10110, 4'd0);
        rom[8]  = ins(5'b10101, 4'd12);
        rom[12] = ins(5'b10110, 4'd0);
        start(1'b1);
        for (int i = 0; i < 7; i++) begin
            tick(1);
            expect_val($sformatf("stk_adr%0d", i), seq4[i]); check(adr);
            expect_val($sformatf("stk_err%0d", i), err4[i]); check(stack_err);
        end
        expect_val("stk_halted", 1); check(halted);

        // Single-step control; r5 follows btn while stalled
        clear_rom();
        rom[0] = ins(5'b10010, 4'd7);
        rom[1] = ins(5'b00110, 4'd0);
        rom[2] = ins(5'b10111, 4'd0);
        btn = 4'd5;
        start(1'b0);
        tick(3);
        expect_val("stall_adr", 0); check(adr);
        read_reg(3'd5, v); expect_val("stall_r5", 5); check(v);
        read_reg(3'd0, v); expect_val("stall_r0", 0); check(v);
        step = 1'b1; tick(1); step = 1'b0;
        expect_val("step_adr", 1); check(adr);
        read_reg(3'd0, v); expect_val("step_r0", 7); check(v);
        tick(2); expect_val("step_once_only", 1); check(adr);
        btn = 4'd9; tick(1);
        read_reg(3'd5, v); expect_val("stall_r5_new", 9); check(v);
        step = 1'b1; tick(1);
        expect_val("step_held_adr", 2); check(adr);
        expect_val("step_held_led", 7); check(led);
        tick(1); step = 1'b0; run = 1'b1;
        expect_val("step_hlt", 1); check(halted);
        tick(3);
        expect_val("halt_run_adr", 2); check(adr);
        expect_val("halt_run_halted", 1); check(halted);

        // Matrix scan readout
        clear_rom();
        rom[0] = ins(5'b10010, 4'd5);
        rom[1] = ins(5'b00010, 4'd0);
        rom[2] = ins(5'b10111, 4'd0);
        start(1'b1);
        tick(3);
        scan_sel = 3'd2; #1;
        expect_val("mat_row_r2", 8'hA0); check(row);
        expect_val("mat_col_2", 8'hDF);  check(col);
        scan_sel = 3'd7; #1;
        expect_val("mat_row_pc", 8'h40); check(row);
        expect_val("mat_col_7", 8'hFE);  check(col);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
